fa_32b_share_ctrl: RTL and testbench

//  Shares one fa_32b instance between NREQ requesters. Per-requester valid/ready

---
 rtl/fa_share_pkg.sv | 7 +
 rtl/fa_32b.sv | 12 +
 rtl/rr_arb.sv | 28 ++
 rtl/fa_32b_share_ctrl.sv | 101 ++++++++++
 tb/tb_fa_32b_share_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fa_share_pkg.sv
// Shared definitions for the fa_32b sharing controller: datapath width and
// the output-slot state encoding.
package fa_share_pkg;
    localparam int WORD_W = 32;

    typedef enum logic {S_EMPTY, S_FULL} slot_state_t;
endpackage

// File: rtl/fa_32b.sv
// 32-bit full adder word with carry in/out; purely combinational.
module fa_32b
    import fa_share_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};
endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: first requesting index at or above ptr_i, wrapping mod NREQ.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    int idx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                idx_o      = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/fa_32b_share_ctrl.sv
// Shares one fa_32b between NREQ requesters with round-robin grant, a per-requester
// carry register for multi-word chains, and a single registered response slot.
module fa_32b_share_ctrl
    import fa_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    input  logic [NREQ-1:0]        req_chain,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WORD_W-1:0]      rsp_sum,
    output logic                   rsp_cout
);
    slot_state_t       state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]   carry_q, carry_d;
    logic [IDW-1:0]    id_q;
    logic [WORD_W-1:0] sum_q;
    logic              cout_q;

    logic              grant_en, any;
    logic [NREQ-1:0]   arb_req, gnt;
    logic [IDW-1:0]    gidx;
    logic [WORD_W-1:0] op_a, op_b, fa_sum;
    logic              op_cin, fa_cout;

    // No grant while reset is asserted, so req_ready reads zero during reset.
    assign grant_en = rst_n && ((state_q == S_EMPTY) || rsp_ready);
    assign arb_req  = req_valid & {NREQ{grant_en}};

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (any)
    );

    assign req_ready = gnt;

    // Subtract is A + ~B + 1; a chained word replaces the +1 with the stored not-borrow.
    assign op_a   = req_a[WORD_W*int'(gidx) +: WORD_W];
    assign op_b   = req_sub[gidx] ? ~req_b[WORD_W*int'(gidx) +: WORD_W]
                                  :  req_b[WORD_W*int'(gidx) +: WORD_W];
    assign op_cin = req_chain[gidx] ? carry_q[gidx] : req_sub[gidx];

    fa_32b u_fa (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (op_cin),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        carry_d = carry_q;
        if (any) begin
            state_d       = S_FULL;
            ptr_d         = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            carry_d[gidx] = fa_cout;
        end else if (rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            carry_q <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            carry_q <= carry_d;
            if (any) begin
                id_q   <= gidx;
                sum_q  <= fa_sum;
                cout_q <= fa_cout;
            end
        end
    end

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_fa_32b_share_ctrl.sv
// Bench for fa_32b_share_ctrl: directed vector table, hand sequences for
// fairness/backpressure/reset, then random traffic against an arithmetic model.
module tb_fa_32b_share_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, req_sub, req_chain;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    fa_32b_share_ctrl #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit        m_full;
    int        m_ptr;
    bit [3:0]  m_carry;
    int        m_id;
    bit [31:0] m_sum;
    bit        m_cout;
    int        m_g;

    typedef struct {
        int          id;
        logic [31:0] a, b;
        bit          sub, chain;
        logic [31:0] es;
        bit          ec;
    } vec_t;
    vec_t tv[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_full = 0; m_ptr = 0; m_carry = '0; m_id = 0; m_sum = '0; m_cout = 0;
    endtask

    function automatic int model_pick();
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_commit();
        logic [31:0] a, b;
        logic        cin;
        logic [32:0] r;
        if (m_g >= 0) begin
            a   = req_a[32*m_g +: 32];
            b   = req_sub[m_g] ? ~req_b[32*m_g +: 32] : req_b[32*m_g +: 32];
            cin = req_chain[m_g] ? m_carry[m_g] : req_sub[m_g];
            r   = {1'b0, a} + {1'b0, b} + 33'(cin);
            m_sum = r[31:0]; m_cout = r[32]; m_id = m_g;
            m_carry[m_g] = r[32];
            m_full = 1;
            m_ptr = (m_g + 1) % 4;
        end else if (rsp_ready) begin
            m_full = 0;
        end
    endtask

    // Called right after inputs are driven at a negedge; returns at the next negedge.
    task automatic step();
        m_g = model_pick();
        #1;
        check("req_ready", 64'(req_ready), (m_g < 0) ? 64'd0 : 64'(4'b1 << m_g));
        @(posedge clk);
        model_commit();
        @(negedge clk);
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        check("rsp_id",    64'(rsp_id),    64'(m_id));
        check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
        check("rsp_cout",  64'(rsp_cout),  64'(m_cout));
    endtask

    task automatic clr();
        req_valid = '0; req_sub = '0; req_chain = '0; req_a = '0; req_b = '0;
    endtask

    task automatic drive1(input int id, input logic [31:0] a, input logic [31:0] b,
                          input bit sub, input bit chain);
        clr();
        req_valid[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_sub[id] = sub;
        req_chain[id] = chain;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'hF;
        model_reset();
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_data",  {31'd0, rsp_cout, rsp_sum}, 64'd0);
        check("rst_id",    64'(rsp_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
    endtask

    initial begin
        logic [31:0] hold_sum;
        logic [1:0]  hold_id;
        logic        hold_cout;

        tv[0] = '{0, 32'h5,         32'h3,         1'b0, 1'b0, 32'h8,         1'b0};
        tv[1] = '{1, 32'h3,         32'h5,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0};
        tv[2] = '{1, 32'h5,         32'h3,         1'b1, 1'b0, 32'h2,         1'b1};
        tv[3] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};
        tv[4] = '{3, 32'h1,         32'h1,         1'b0, 1'b0, 32'h2,         1'b0};
        tv[5] = '{2, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1,         1'b0};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        clr();
        model_reset();
        #12;
        do_reset();

        // Directed vectors: single add, subtract with/without borrow, interleaved 64-bit chain
        foreach (tv[i]) begin
            drive1(tv[i].id, tv[i].a, tv[i].b, tv[i].sub, tv[i].chain);
            rsp_ready = 1'b1;
            step();
            check($sformatf("tv%0d_id", i),   64'(rsp_id),   64'(tv[i].id));
            check($sformatf("tv%0d_sum", i),  64'(rsp_sum),  64'(tv[i].es));
            check($sformatf("tv%0d_cout", i), 64'(rsp_cout), 64'(tv[i].ec));
        end
        clr();
        step();

        // Fairness: all valid, consumer always ready
        do_reset();
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'hF;
            req_a = {32'd4, 32'd3, 32'd2, 32'd1};
            rsp_ready = 1'b1;
            step();
            check("fair_id", 64'(rsp_id), 64'(k % 4));
        end

        // Backpressure: slot full, consumer stalled for 5 cycles
        drive1(1, 32'h10, 32'h20, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        step();
        hold_sum = rsp_sum; hold_id = rsp_id; hold_cout = rsp_cout;
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'hF;
            step();
        end
        check("bp_hold", {29'd0, hold_cout, hold_id, hold_sum}, {29'd0, rsp_cout, rsp_id, rsp_sum});
        check("bp_hold_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        clr();
        step();

        // Reset mid-chain: stored carry must be cleared
        drive1(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        check("mc_w0_cout", 64'(rsp_cout), 64'd1);
        do_reset();
        drive1(0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        check("mc_after_sum",  64'(rsp_sum),  64'd0);
        check("mc_after_cout", 64'(rsp_cout), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_sub   = 4'($urandom);
            req_chain = 4'($urandom);
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            if (k % 7 == 0) req_a[31:0] = 32'hFFFF_FFFF;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
